branch_history_tracker: RTL

//  Speculative global branch history register (GHR) feeding the TAGE predictor's prediction history input.
//  Per in-flight branch: checkpoints the history used for its prediction, restores it on mispredict.

---
 rtl/branch_history_tracker_pkg.sv | 31 +++
 rtl/branch_history_tracker.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/branch_history_tracker_pkg.sv
// Shared types for the speculative global branch history tracker.
//   BHist_t  : global history vector (width sets the tracker's default HIST_LEN)
//   BrID_t   : checkpoint ID for an in-flight branch
//   BHCkpt_t : one checkpoint entry (history plus low path address bits)
// Optional feature macro: BHT_PATH_HIST_EN. When it is defined, the shifted-in
// history bit is the taken bit mixed with address bits [1:0].
package branch_history_tracker_pkg;

    localparam int BHT_HIST_LEN = 16;
    localparam int BHT_NUM_CKPT = 8;
    localparam int BHT_ID_W     = $clog2(BHT_NUM_CKPT);

    typedef logic [BHT_HIST_LEN-1:0] BHist_t;
    typedef logic [BHT_ID_W-1:0]     BrID_t;

    typedef struct packed {
        BHist_t     hist;
        logic [1:0] pathBits;
    } BHCkpt_t;

    // History bit shifted in for a branch with direction taken and low address bits path.
    function automatic logic shift_in_bit(input logic taken, input logic [1:0] path);
`ifdef BHT_PATH_HIST_EN
        return taken ^ path[1] ^ path[0];
`else
        // Plain direction history: the address bits do not contribute.
        return taken ^ (1'b0 & (path[1] | path[0]));
`endif
    endfunction

endpackage

// File: rtl/branch_history_tracker.sv
// Speculative global branch history register (GHR) for the TAGE predictor.
// Every predicted branch checkpoints the history it was predicted with. A
// mispredict restores the history from the checkpoint of the mispredicted
// branch. At commit the checkpoints come out in order as the TAGE update history.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   IN_predValid/Taken/Addr : new predicted branch (address in halfword units)
//   OUT_ready         : a checkpoint slot is free (queue not full)
//   OUT_predID        : ID given to the branch presented this cycle
//   OUT_history       : current speculative history -> TAGE prediction history
//   IN_mispredValid/ID/Taken : resolved mispredict and its actual direction
//   IN_commitValid    : oldest in-flight branch commits
//   OUT_commitValid   : registered one-cycle pulse per commit
//   OUT_commitHistory : history the committed branch predicted with
//
// Optional feature macro: BHT_PATH_HIST_EN (path-mixed history; the checkpoints
// also store IN_predAddr[1:0] so a mispredict can recompute the shifted-in bit).
module branch_history_tracker
    import branch_history_tracker_pkg::*;
#(
    parameter int HIST_LEN = $bits(BHist_t),
    parameter int NUM_CKPT = 8,
    parameter int ID_W     = $clog2(NUM_CKPT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IN_predValid,
    input  logic                IN_predTaken,
    input  logic [30:0]         IN_predAddr,
    output logic                OUT_ready,
    output logic [ID_W-1:0]     OUT_predID,
    output logic [HIST_LEN-1:0] OUT_history,
    input  logic                IN_mispredValid,
    input  logic [ID_W-1:0]     IN_mispredID,
    input  logic                IN_mispredTaken,
    input  logic                IN_commitValid,
    output logic                OUT_commitValid,
    output logic [HIST_LEN-1:0] OUT_commitHistory
);

    localparam int PTR_W = ID_W + 1;

    logic [HIST_LEN-1:0] ghr_r;
    logic [HIST_LEN-1:0] ckpt_hist_r [NUM_CKPT];
`ifdef BHT_PATH_HIST_EN
    logic [1:0]          ckpt_path_r [NUM_CKPT];
`endif
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic                commit_valid_r;
    logic [HIST_LEN-1:0] commit_hist_r;

    logic                empty_s;
    logic                full_s;
    logic                pred_fire_s;
    logic                commit_fire_s;
    logic                mis_fire_s;
    logic [PTR_W-1:0]    count_s;
    logic [ID_W-1:0]     mis_off_s;
    logic [PTR_W-1:0]    mis_tail_s;
    logic [1:0]          pred_path_s;
    logic [1:0]          mis_path_s;
    logic                pred_bit_s;
    logic                mis_bit_s;
    logic                unused_addr_s;

    // Queue status, event qualification and shifted-in history bits.
    always_comb begin
        empty_s       = (head_r == tail_r);
        full_s        = (head_r[ID_W-1:0] == tail_r[ID_W-1:0]) && (head_r[ID_W] != tail_r[ID_W]);
        count_s       = tail_r - head_r;
        // Age of the mispredicted ID relative to the oldest branch; it is in flight
        // only if that age is below the occupancy.
        mis_off_s     = IN_mispredID - head_r[ID_W-1:0];
        mis_fire_s    = IN_mispredValid && ({1'b0, mis_off_s} < count_s);
        // Restart just after the mispredicted entry; the add keeps its wrap bit.
        mis_tail_s    = head_r + {1'b0, mis_off_s} + {{ID_W{1'b0}}, 1'b1};
        // A mispredict takes priority and drops any same-cycle predict.
        pred_fire_s   = IN_predValid && !full_s && !IN_mispredValid;
        commit_fire_s = IN_commitValid && !empty_s;
        pred_path_s   = IN_predAddr[1:0];
`ifdef BHT_PATH_HIST_EN
        mis_path_s    = ckpt_path_r[IN_mispredID];
`else
        mis_path_s    = 2'b00;
`endif
        pred_bit_s    = shift_in_bit(IN_predTaken, pred_path_s);
        mis_bit_s     = shift_in_bit(IN_mispredTaken, mis_path_s);
        unused_addr_s = ^IN_predAddr;
    end

    // Speculative history, checkpoint array and tail pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_r  <= {HIST_LEN{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            for (int i = 0; i < NUM_CKPT; i++) begin
                ckpt_hist_r[i] <= {HIST_LEN{1'b0}};
`ifdef BHT_PATH_HIST_EN
                ckpt_path_r[i] <= 2'b00;
`endif
            end
        end else if (mis_fire_s) begin
            // The mispredicted checkpoint stays; only younger entries are squashed.
            ghr_r  <= {ckpt_hist_r[IN_mispredID][HIST_LEN-2:0], mis_bit_s};
            tail_r <= mis_tail_s;
        end else if (pred_fire_s) begin
            ckpt_hist_r[tail_r[ID_W-1:0]] <= ghr_r;
`ifdef BHT_PATH_HIST_EN
            ckpt_path_r[tail_r[ID_W-1:0]] <= pred_path_s;
`endif
            ghr_r  <= {ghr_r[HIST_LEN-2:0], pred_bit_s};
            tail_r <= tail_r + {{ID_W{1'b0}}, 1'b1};
        end else begin
            ghr_r  <= ghr_r;
            tail_r <= tail_r;
        end
    end

    // In-order commit: registered history of the oldest branch, one pulse per commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r         <= {PTR_W{1'b0}};
            commit_valid_r <= 1'b0;
            commit_hist_r  <= {HIST_LEN{1'b0}};
        end else if (commit_fire_s) begin
            head_r         <= head_r + {{ID_W{1'b0}}, 1'b1};
            commit_valid_r <= 1'b1;
            commit_hist_r  <= ckpt_hist_r[head_r[ID_W-1:0]];
        end else begin
            head_r         <= head_r;
            commit_valid_r <= 1'b0;
            commit_hist_r  <= commit_hist_r;
        end
    end

    assign OUT_ready         = !full_s;
    assign OUT_predID        = tail_r[ID_W-1:0];
    assign OUT_history       = ghr_r;
    assign OUT_commitValid   = commit_valid_r;
    assign OUT_commitHistory = commit_hist_r;

endmodule
